// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;
  localparam int unsigned XLEN       = 32;
  localparam int unsigned WORD_BYTES = 4;
  localparam logic [1:0]  ALIGN_MASK = 2'b11;

  typedef enum logic [1:0] {RUN, IDLE, FAULT} state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fq_entry_t;
endpackage

// File: rtl/instr_fetch_unit_if.sv
// Decode-side valid/ready handshake carrying {pc, instruction}.
interface instr_fetch_unit_if;
  logic        ir_valid;
  logic        ir_ready;
  logic [31:0] ir_out;
  logic [31:0] ir_pc;

  modport master (output ir_valid, output ir_out, output ir_pc, input ir_ready);
  modport slave  (input ir_valid, input ir_out, input ir_pc, output ir_ready);
endinterface

// File: rtl/fetch_queue.sv
// Two-entry shift FIFO: slot0 is always the head, so head outputs come straight from flops.
module fetch_queue
  import fetch_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  logic       push,
  input  logic       pop,
  input  fq_entry_t  wr_entry,
  output fq_entry_t  head,
  output logic       head_valid,
  output logic [1:0] count_c
);
  fq_entry_t slot0_q, slot0_d, slot1_q, slot1_d;
  logic      v0_q, v0_d, v1_q, v1_d;

  // Flush beats push; push+pop when full shifts and refills the tail.
  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    v0_d    = v0_q;
    v1_d    = v1_q;
    if (flush) begin
      v0_d = 1'b0;
      v1_d = 1'b0;
    end else if (push && pop) begin
      if (v1_q) begin
        slot0_d = slot1_q;
        slot1_d = wr_entry;
      end else begin
        slot0_d = wr_entry;
      end
    end else if (push) begin
      if (!v0_q) begin
        slot0_d = wr_entry;
        v0_d    = 1'b1;
      end else begin
        slot1_d = wr_entry;
        v1_d    = 1'b1;
      end
    end else if (pop) begin
      // Head data is left untouched when the queue empties.
      if (v1_q) slot0_d = slot1_q;
      v0_d = v1_q;
      v1_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot0_q <= '0;
      slot1_q <= '0;
      v0_q    <= 1'b0;
      v1_q    <= 1'b0;
    end else begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      v0_q    <= v0_d;
      v1_q    <= v1_d;
    end
  end

  assign head       = slot0_q;
  assign head_valid = v0_q;
  assign count_c    = 2'(v0_q) + 2'(v1_q);
endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch sequencer: PC register, RUN/IDLE/FAULT FSM, redirect handling and fetch queue.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned QDEPTH   = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      fetch_en,
  output logic [31:0]               pc_address,
  input  logic [31:0]               imem_ir,
  input  logic                      redirect_valid,
  input  logic [31:0]               redirect_target,
  instr_fetch_unit_if.master        ir_if,
  output logic                      fault
);
  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        fault_q, fault_d;

  logic        redir, misalign, pop, push;
  logic [1:0]  count;
  logic        head_valid;
  fq_entry_t   head, wr_entry;

  assign redir    = redirect_valid && (state_q != FAULT);
  assign misalign = |(redirect_target[1:0] & ALIGN_MASK);
  assign pop      = head_valid && ir_if.ir_ready;
  // Any redirect request (even a misaligned one) suppresses the push.
  assign push     = (state_q == RUN) && fetch_en && !redirect_valid &&
                    ((32'(count) < QDEPTH) || pop);
  assign wr_entry = '{pc: fetch_pc_q, instr: imem_ir};

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    fault_d    = fault_q;
    unique case (state_q)
      RUN:     if (!fetch_en) state_d = IDLE;
      IDLE:    if (fetch_en)  state_d = RUN;
      FAULT:   state_d = FAULT;
      default: state_d = FAULT;
    endcase
    if (redir && misalign) begin
      state_d = FAULT;
      fault_d = 1'b1;
    end else if (redir) begin
      fetch_pc_d = redirect_target;
    end else if (push) begin
      fetch_pc_d = fetch_pc_q + 32'(WORD_BYTES);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      fetch_pc_q <= RESET_PC;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      fault_q    <= fault_d;
    end
  end

  fetch_queue u_queue (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (redir),
    .push       (push),
    .pop        (pop),
    .wr_entry   (wr_entry),
    .head       (head),
    .head_valid (head_valid),
    .count_c    (count)
  );

  assign pc_address     = fetch_pc_q;
  assign fault          = fault_q;
  assign ir_if.ir_valid = head_valid;
  assign ir_if.ir_out   = head.instr;
  assign ir_if.ir_pc    = head.pc;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a combinational word-indexed memory model.
module tb_instr_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_en;
  logic [31:0] pc_address;
  logic [31:0] imem_ir;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        fault;
  int          n_checks = 0;
  int          n_errors = 0;

  instr_fetch_unit_if dec_if ();

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .QDEPTH(2)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .fetch_en        (fetch_en),
    .pc_address      (pc_address),
    .imem_ir         (imem_ir),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .ir_if           (dec_if),
    .fault           (fault)
  );

  always #5 clk = ~clk;

  // Memory content: word at byte address a is 0x1000_0000 + a/4.
  function automatic logic [31:0] word(input logic [31:0] a);
    return 32'h1000_0000 + {2'b00, a[31:2]};
  endfunction

  assign imem_ir = word(pc_address);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic check_head(input string tag, input logic [31:0] exp_pc);
    check({tag, "_valid"}, 32'(dec_if.ir_valid), 32'd1);
    check({tag, "_pc"},    dec_if.ir_pc,  exp_pc);
    check({tag, "_ir"},    dec_if.ir_out, word(exp_pc));
  endtask

  initial begin
    rst_n           = 1'b0;
    fetch_en        = 1'b1;
    redirect_valid  = 1'b0;
    redirect_target = 32'h0;
    dec_if.ir_ready = 1'b1;
    tick(); tick();
    check("rst_pc",    pc_address, 32'h0);
    check("rst_valid", 32'(dec_if.ir_valid), 32'd0);
    check("rst_ir",    dec_if.ir_out, 32'h0);
    check("rst_irpc",  dec_if.ir_pc, 32'h0);
    check("rst_fault", 32'(fault), 32'd0);
    rst_n = 1'b1;

    // Streaming at one instruction per cycle.
    for (int k = 1; k <= 4; k++) begin
      tick();
      check("stream_addr", pc_address, 32'(4 * k));
      check_head("stream", 32'(4 * (k - 1)));
    end

    // Asynchronous reset mid-stream.
    rst_n = 1'b0;
    #1;
    check("async_valid", 32'(dec_if.ir_valid), 32'd0);
    check("async_pc",    pc_address, 32'h0);
    dec_if.ir_ready = 1'b0;
    tick();
    rst_n = 1'b1;

    // Stall: queue fills to two, PC holds at 8.
    tick();
    check_head("stall1", 32'h0);
    check("stall1_addr", pc_address, 32'h4);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("stall_addr", pc_address, 32'h8);
      check_head("stall_hold", 32'h0);
    end
    dec_if.ir_ready = 1'b1;
    tick(); check_head("rel0", 32'h4); check("rel0_addr", pc_address, 32'hC);
    tick(); check_head("rel1", 32'h8); check("rel1_addr", pc_address, 32'h10);
    tick(); check_head("rel2", 32'hC); check("rel2_addr", pc_address, 32'h14);

    // Redirect with a full queue and a concurrent pop.
    redirect_valid  = 1'b1;
    redirect_target = 32'h40;
    tick();
    redirect_valid = 1'b0;
    check("redir_valid", 32'(dec_if.ir_valid), 32'd0);
    check("redir_addr",  pc_address, 32'h40);
    tick(); check_head("redir0", 32'h40); check("redir0_addr", pc_address, 32'h44);
    tick(); check_head("redir1", 32'h44); check("redir1_addr", pc_address, 32'h48);

    // fetch_en low: PC freezes, queue drains, one idle cycle on resume.
    fetch_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("frz_valid", 32'(dec_if.ir_valid), 32'd0);
      check("frz_addr",  pc_address, 32'h48);
    end
    fetch_en = 1'b1;
    tick();
    check("resume_idle", 32'(dec_if.ir_valid), 32'd0);
    check("resume_addr", pc_address, 32'h48);
    tick(); check_head("resume", 32'h48); check("resume1_addr", pc_address, 32'h4C);

    // Redirect to the top word, then wrap to zero.
    redirect_valid  = 1'b1;
    redirect_target = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    check("wrap_addr", pc_address, 32'hFFFF_FFFC);
    tick(); check_head("wrap0", 32'hFFFF_FFFC); check("wrap0_addr", pc_address, 32'h0);
    tick(); check_head("wrap1", 32'h0);         check("wrap1_addr", pc_address, 32'h4);

    // Misaligned redirect traps; later redirects ignored.
    redirect_valid  = 1'b1;
    redirect_target = 32'h42;
    tick();
    redirect_valid = 1'b0;
    check("flt_fault", 32'(fault), 32'd1);
    check("flt_valid", 32'(dec_if.ir_valid), 32'd0);
    check("flt_addr",  pc_address, 32'h4);
    tick();
    check("flt_hold_valid", 32'(dec_if.ir_valid), 32'd0);
    redirect_valid  = 1'b1;
    redirect_target = 32'h80;
    tick();
    redirect_valid = 1'b0;
    tick();
    check("flt_ign_addr",  pc_address, 32'h4);
    check("flt_ign_fault", 32'(fault), 32'd1);
    check("flt_ign_valid", 32'(dec_if.ir_valid), 32'd0);

    // Reset clears the trap and fetching restarts at RESET_PC.
    rst_n = 1'b0;
    #1;
    check("clr_fault", 32'(fault), 32'd0);
    check("clr_pc",    pc_address, 32'h0);
    tick();
    rst_n = 1'b1;
    tick(); check_head("post_rst", 32'h0); check("post_rst_addr", pc_address, 32'h4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Fetch sequencer for the instruction memory. It owns the program counter, drives the memory's byte address each cycle and captures the returned word into a 2-entry fetch queue. It hands {pc, instruction} pairs to decode over a valid/ready handshake. It also accepts branch/jump redirects and traps misaligned targets. It sits between `instruction_memory` (combinational read, word index = address/4) and the decode stage.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000: byte address fetched first after reset; must be word-aligned.
- `QDEPTH`, 2: fetch queue entries; fixed at 2 for this revision.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `fetch_en`  in  1  enables fetching; low freezes the PC, but the queue still drains.
- `pc_address`  out  32  byte address to `instruction_memory`; equals the internal `fetch_pc` register (combinational from the register).
- `imem_ir`  in  32  word returned by `instruction_memory` in the same cycle.
- `redirect_valid`  in  1  branch/jump taken this cycle.
- `redirect_target`  in  32  new byte PC, sampled when `redirect_valid`=1.
- `ir_valid`  out  1  queue head valid.
- `ir_ready`  in  1  decode accepts the head.
- `ir_out`  out  32  head instruction.
- `ir_pc`  out  32  byte PC of the head instruction.
- `fault`  out  1  sticky misaligned-redirect trap.

## Operation
- States: RUN, IDLE, FAULT.
  - RUN→IDLE when `fetch_en`=0. IDLE→RUN when `fetch_en`=1.
  - Any state except FAULT →FAULT on a redirect with `redirect_target[1:0]`≠0.
  - FAULT is exited only by reset.
- pop = `ir_valid` & `ir_ready`.
- push = state RUN & `fetch_en` & no redirect & (count<2 | pop). A push writes {`fetch_pc`, `imem_ir`} at the queue tail, then `fetch_pc` += 4.
- PC arithmetic is 32-bit unsigned: 32'hFFFF_FFFC + 4 wraps to 0. No range check against memory depth.
- Aligned redirect, in any non-FAULT state:
  - flushes the queue (count←0); a same-cycle pop is still legal and is the last one accepted;
  - sets `fetch_pc`←target;
  - no push occurs that cycle.
- Redirect priority: redirect over push and over pop-only queue updates.
- Misaligned redirect: flushes the queue, leaves `fetch_pc` unchanged, sets `fault`=1 and enters FAULT. In FAULT: no push, `ir_valid`=0, redirects ignored.
- Push and pop in the same cycle with count=2 is legal; count stays 2.
- `ir_out`/`ir_pc` hold their last value when `ir_valid`=0. Their content is undefined for the checker in that case.

## Timing
- Reset values:
  - `fetch_pc`=`RESET_PC` (so `pc_address`=`RESET_PC` immediately)
  - count=0, `ir_valid`=0, `ir_out`=0, `ir_pc`=0, `fault`=0
  - state=RUN
- Fetch latency: address presented in cycle N, word captured at the end of N, `ir_valid`=1 in N+1.
- Throughput: 1 instruction/cycle while decode holds `ir_ready`=1.
- Redirect in cycle N: `pc_address`=target in N+1; first target instruction is valid in N+2. Queue entries older than the redirect are never presented after N.
- `ir_ready`=0 with count=2: push stops and `pc_address` holds. Fetch resumes in the cycle `ir_ready` rises (push+pop).
- `rst_n` asserted mid-operation: all state returns to reset values asynchronously. The first fetch happens on the first rising edge after deassertion.

## Structure
- Package `fetch_pkg`:
  - state enum {RUN, IDLE, FAULT};
  - `WORD_BYTES`=4;
  - `ALIGN_MASK`=2'b11;
  - queue entry struct {pc[31:0], instr[31:0]}.
- Sub-module `fetch_queue`: 2-entry synchronous FIFO with push, pop and flush. Flush has priority over push. Push+pop when full is allowed. Outputs head, valid and count.
- Top level holds the PC register, the FSM and the push/redirect logic.

## Test plan
- Reset, `RESET_PC`=0, memory words 0..3 = A,B,C,D, `ir_ready`=1 → `pc_address` 0,4,8,C on successive cycles; `ir_out` A,B,C,D starting cycle 1, `ir_pc` 0,4,8,C.
- `ir_ready`=0 for 4 cycles after the first valid → count saturates at 2 and `pc_address` holds at 8. On release, A,B,C are delivered with no gap and no duplicate.
- Redirect to 32'h40 in the same cycle as a push/pop with count=2 → queue flushed; next two outputs are mem[0x40/4] with `ir_pc`=0x40, then `ir_pc`=0x44; no stale word appears.
- Redirect to 32'h42 → `fault`=1 next cycle, `ir_valid`=0 thereafter; a later aligned redirect is ignored; reset clears `fault`.
- `fetch_en`=0 for 3 cycles mid-stream → PC frozen, queued words drain; fetching resumes at the frozen PC when `fetch_en` returns to 1.
- Redirect to 32'hFFFF_FFFC → next `ir_pc` values are FFFF_FFFC, then 0000_0000 (wrap); `rst_n` pulsed low mid-stream → `ir_valid`=0 immediately, `pc_address`=`RESET_PC`.
